// File: rtl/eu_xbuf_mp_pkg.sv
// Shared types for the multi-port execution-unit operand buffer.
package pkg_dtypes;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    logic               valid;
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_xbuf_mp_entry;

endpackage

// File: rtl/eu_xbuf_mp_cam_match.sv
// Associative tag compare of one key against every stored tag; only valid entries can match.
module eu_xbuf_cam_match
  import pkg_dtypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]   valid,
  input  type_exec_unit_addr tags [DEPTH],
  input  type_exec_unit_addr key,
  output logic [DEPTH-1:0]   match,
  output logic               hit
);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tags[i] == key);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/eu_xbuf_mp.sv
// Fully associative operand buffer: tagged writes, NUM_REQ_PORTS lookup ports,
// free on read and/or explicit retire, exact registered occupancy.
module eu_xbuf_mp
  import pkg_dtypes::*;
#(
  parameter int NUM_IDX_BITS   = 2,
  parameter int NUM_REQ_PORTS  = 2,
  parameter bit RETIRE_ON_READ = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  type_exec_unit_addr       in_addr_i,
  input  type_exec_unit_data       in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  type_exec_unit_addr       req_addr_i [NUM_REQ_PORTS],
  input  logic [NUM_REQ_PORTS-1:0] req_valid_i,
  output type_exec_unit_data       resp_data_o [NUM_REQ_PORTS],
  output logic [NUM_REQ_PORTS-1:0] resp_success_o,
  input  type_exec_unit_addr       retire_addr_i,
  input  logic                     retire_valid_i,
  output logic [NUM_IDX_BITS:0]    count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int DEPTH = 2 ** NUM_IDX_BITS;
  localparam logic [NUM_IDX_BITS:0] DEPTH_CNT = (NUM_IDX_BITS + 1)'(DEPTH);

  type_xbuf_mp_entry  entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_vec;
  type_exec_unit_addr tag_vec [DEPTH];
  logic [NUM_IDX_BITS:0] count_q;

  logic [DEPTH-1:0] wr_match, rt_match, alloc_sel, wr_sel, clr_vec, valid_nxt;
  logic             wr_hit, rt_hit, wr_fire, alloc_found;
  logic [DEPTH-1:0] rq_match [NUM_REQ_PORTS];
  logic [NUM_REQ_PORTS-1:0] rq_hit;

  type_exec_unit_data       resp_data_p0 [NUM_REQ_PORTS];
  logic [NUM_REQ_PORTS-1:0] vld_p0;
  type_exec_unit_data       resp_data_p1 [NUM_REQ_PORTS];
  logic [NUM_REQ_PORTS-1:0] vld_p1;

  function automatic logic [NUM_IDX_BITS:0] popcount(input logic [DEPTH-1:0] v);
    logic [NUM_IDX_BITS:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{NUM_IDX_BITS{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entry_q[i].valid;
      tag_vec[i]   = entry_q[i].addr;
    end
  end

  eu_xbuf_cam_match #(.DEPTH(DEPTH)) u_cam_wr (
    .valid (valid_vec),
    .tags  (tag_vec),
    .key   (in_addr_i),
    .match (wr_match),
    .hit   (wr_hit)
  );

  eu_xbuf_cam_match #(.DEPTH(DEPTH)) u_cam_rt (
    .valid (valid_vec),
    .tags  (tag_vec),
    .key   (retire_addr_i),
    .match (rt_match),
    .hit   (rt_hit)
  );

  for (genvar p = 0; p < NUM_REQ_PORTS; p++) begin : g_req
    eu_xbuf_cam_match #(.DEPTH(DEPTH)) u_cam_rq (
      .valid (valid_vec),
      .tags  (tag_vec),
      .key   (req_addr_i[p]),
      .match (rq_match[p]),
      .hit   (rq_hit[p])
    );
  end

  // Readiness sees only stored state and the write tag, so same-cycle frees never unblock a full buffer.
  assign in_ready_o = ~full_o | wr_hit;
  assign wr_fire    = in_valid_i & in_ready_o;

  always_comb begin
    alloc_sel   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_sel[i] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
  end

  always_comb begin
    wr_sel = '0;
    if (wr_fire) wr_sel = wr_hit ? wr_match : alloc_sel;
  end

  // Frees are OR-ed, so several ports hitting one entry clear it once; a write to the same slot wins.
  always_comb begin
    clr_vec = '0;
    if (retire_valid_i && rt_hit) clr_vec = rt_match;
    if (RETIRE_ON_READ) begin
      for (int p = 0; p < NUM_REQ_PORTS; p++) begin
        if (req_valid_i[p]) clr_vec = clr_vec | rq_match[p];
      end
    end
    valid_nxt = (valid_vec & ~clr_vec) | wr_sel;
  end

  always_comb begin
    for (int p = 0; p < NUM_REQ_PORTS; p++) begin
      vld_p0[p]       = req_valid_i[p] & rq_hit[p];
      resp_data_p0[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (req_valid_i[p] && rq_match[p][i]) resp_data_p0[p] = resp_data_p0[p] | entry_q[i].data;
      end
    end
  end

  // p0 -> p1: entry array, occupancy and lookup responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].valid <= valid_nxt[i];
        if (wr_sel[i]) begin
          entry_q[i].addr <= in_addr_i;
          entry_q[i].data <= in_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      vld_p1  <= '0;
      for (int p = 0; p < NUM_REQ_PORTS; p++) resp_data_p1[p] <= '0;
    end else begin
      count_q <= popcount(valid_nxt);
      vld_p1  <= vld_p0;
      for (int p = 0; p < NUM_REQ_PORTS; p++) resp_data_p1[p] <= resp_data_p0[p];
    end
  end

  assign resp_success_o = vld_p1;
  assign resp_data_o    = resp_data_p1;
  assign count_o        = count_q;
  assign full_o         = (count_q == DEPTH_CNT);
  assign empty_o        = (count_q == '0);

endmodule

// File: doc/eu_xbuf_mp.md
# eu_xbuf_mp

Multi-port, address-tagged operand buffer for the execution unit cache. It is a parametrised successor of the single-port x-buffer. Results arriving from the interconnect are written in with an address tag, then looked up associatively by up to `NUM_REQ_PORTS` ALU operand requesters. Entries are freed either on read or through an explicit retire port. Occupancy tracking is exact, with full/empty flags.

## Interface
Parameters:
- `NUM_IDX_BITS`, 2 — depth is `2**NUM_IDX_BITS` entries.
- `NUM_REQ_PORTS`, 2 — number of independent lookup ports.
- `RETIRE_ON_READ`, 1 — 1: a successful lookup frees the entry; 0: entries persist until explicitly retired.

Ports:
- `clk`  in  1  — clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `in_addr_i`  in  `type_exec_unit_addr`  — write tag.
- `in_data_i`  in  `type_exec_unit_data`  — write data.
- `in_valid_i`  in  1  — write request.
- `in_ready_o`  out  1  — write accepted when `in_valid_i & in_ready_o`.
- `req_addr_i`  in  `[NUM_REQ_PORTS]` × `type_exec_unit_addr`  — lookup tags.
- `req_valid_i`  in  `NUM_REQ_PORTS`  — lookup requests.
- `resp_data_o`  out  `[NUM_REQ_PORTS]` × `type_exec_unit_data`  — registered lookup data.
- `resp_success_o`  out  `NUM_REQ_PORTS`  — registered hit flag, one cycle after the request.
- `retire_addr_i`  in  `type_exec_unit_addr`  — explicit free tag.
- `retire_valid_i`  in  1  — explicit free request.
- `count_o`  out  `NUM_IDX_BITS+1`  — number of valid entries.
- `full_o`  out  1  — `count_o == 2**NUM_IDX_BITS`.
- `empty_o`  out  1  — `count_o == 0`.

## Operation
- Storage is `2**NUM_IDX_BITS` entries, each holding `{valid, addr, data}`. The buffer is fully associative.
- **Write match:** if a valid entry already holds `in_addr_i`, an accepted write overwrites its data in place. No new slot is used and the count is unchanged.
- **Write allocate:** otherwise an accepted write goes to the lowest-index invalid entry and the count increments.
- **Write readiness:** `in_ready_o = ~full_o | tag_match(in_addr_i)`. It depends only on registered state and `in_addr_i`. There is no path from the req or retire ports to `in_ready_o`, so a retire in the same cycle does not unblock a write while full.
- **Lookup:** each port compares its tag against all valid entries in the request cycle. On a hit, the port's `resp_success_o` goes to 1 and `resp_data_o` carries the entry data on the next cycle. On a miss or an idle port, both outputs are 0. Ports are fully independent; several ports may hit the same entry in the same cycle.
- **Retire on read:** when `RETIRE_ON_READ=1`, each hit entry is invalidated at the end of the request cycle. An entry hit by several ports in one cycle is freed once and the count drops by 1.
- **Explicit retire:** `retire_valid_i` with a matching entry invalidates that entry. A miss is ignored. This port is active in both modes.
- **Simultaneous events:** a write to address A in the same cycle as a retire of A, or as a read-retire of A, leaves A valid with the new data. The write wins, and the count reflects the net change.
- **Count:** `count_o` is the registered popcount after each edge. It is exact for any mix of allocate, overwrite and multiple frees in one cycle.

## Timing
- **Reset:** asynchronous clear. All entries become invalid and outputs are `resp_success_o=0`, `resp_data_o=0`, `count_o=0`, `full_o=0`, `empty_o=1`, `in_ready_o=1`. Deassertion is synchronised externally. A reset mid-operation discards all contents and any pending responses.
- **Write-to-lookup latency:** 1 cycle. A write accepted in cycle N is visible to lookups issued in cycle N+1. There is no same-cycle bypass: a lookup of A in the same cycle as the write of A misses.
- **Lookup latency:** 1 cycle, request in cycle N and response in cycle N+1. `resp_*` holds for one cycle only.
- **Free timing:** a retire or read-free in cycle N makes the slot allocatable, and `full_o` reflects it, from cycle N+1.
- **Flag timing:** `count_o`, `full_o` and `empty_o` are registered and update on the same edge as the entry valid bits.

## Structure
- In `pkg_dtypes`: `type_xbuf_mp_entry` (`valid`, `addr`, `data`). The entry count is derived locally as `2**NUM_IDX_BITS`.
- Sub-module `eu_xbuf_cam_match`: one tag against the entry array, producing a one-hot match vector plus hit. It is instantiated `NUM_REQ_PORTS+2` times, once per lookup port, once for write and once for retire.
- The free-slot priority encoder and the popcount live in the top module.

## Test plan
Bench configuration is `NUM_IDX_BITS=2`, `NUM_REQ_PORTS=2`.
- **Reset and basic hit/miss:** after reset, write A=0x3/D=0x55. On the next cycle, port0 requests 0x3 and port1 requests 0x7 → one cycle later `resp_success_o=2'b01` and `resp_data_o[0]=0x55`. With `RETIRE_ON_READ=1`, `count_o` then shows 0.
- **Fill to full:** write tags 1,2,3,4 → `full_o=1`, `count_o=4`. A write of new tag 5 sees `in_ready_o=0`. A write of tag 2 with D=0xAA sees `in_ready_o=1`, overwrites in place, and `count_o` stays 4.
- **Dual hit on one entry:** in one cycle, both ports request the same tag → both succeed, `count_o` drops by exactly 1, and a lookup of that tag on the next cycle misses.
- **Write/retire race:** with `RETIRE_ON_READ=0` and tag 6 held, issue `retire_valid_i` for 6 and a write of 6/D=0x11 in the same cycle → tag 6 stays valid with 0x11 and the count is unchanged.
- **Full plus retire:** with the buffer full, retire one tag while a new-tag write is pending → `in_ready_o=0` in that cycle, 1 on the next cycle, and the write then allocates the freed index.
- **Reset mid-operation:** assert `reset_n` low asynchronously while a lookup is in flight → all outputs immediately take their reset values, and every tag misses after release.
